// File: rtl/booth_pkg.sv
// Shared constants for the time-shared radix-2 Booth multiplier scheduler.
package booth_pkg;

    localparam int W_DEFAULT = 5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        RESP = ST_RESP
    } state_t;

    // Booth recode of {Q[0], q-1}; the other two codes leave A unchanged.
    localparam logic [1:0] RC_ADD = 2'b01;
    localparam logic [1:0] RC_SUB = 2'b10;

endpackage

// File: rtl/booth_step_dp.sv
// One radix-2 Booth step: recode {Q[0], q-1}, add/subtract M into A, then
// arithmetic-shift {A, Q, q-1} right by one.
module booth_step_dp
    import booth_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic [W:0]   i_a,
    input  logic [W-1:0] i_q,
    input  logic         i_qm1,
    input  logic [W:0]   i_m,
    output logic [W:0]   o_a,
    output logic [W-1:0] o_q,
    output logic         o_qm1
);

    logic [W:0] w_sum;

    always_comb begin
        case ({i_q[0], i_qm1})
            RC_ADD:  w_sum = i_a + i_m;
            RC_SUB:  w_sum = i_a - i_m;
            default: w_sum = i_a;
        endcase
        o_a   = {w_sum[W], w_sum[W:1]};
        o_q   = {w_sum[0], i_q[W-1:1]};
        o_qm1 = i_q[0];
    end

endmodule

// File: rtl/booth_mul_sched.sv
// Round-robin scheduler in front of one iterative Booth multiplier shared by
// two requesters; returns a 2W-bit signed product tagged with the owner ID.
module booth_mul_sched
    import booth_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    output logic           req0_ready,
    input  logic           req1_valid,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    output logic           req1_ready,
    output logic           rsp_valid,
    output logic           rsp_id,
    output logic [2*W-1:0] rsp_ans,
    input  logic           rsp_ready,
    output logic           busy,
    output state_t         dbg_state
);

    // Handshake: a transfer happens on any rising edge where valid and ready
    // are both high; requesters hold operands until ready, consumer likewise.
    localparam int CW = $clog2(W + 1);

    state_t         r_state;
    state_t         w_next;
    logic           r_last;
    logic           r_id;
    logic [W:0]     r_m;
    logic [W:0]     r_a;
    logic [W-1:0]   r_q;
    logic           r_qm1;
    logic [CW-1:0]  r_cnt;

    logic           w_g0;
    logic           w_g1;
    logic           w_accept;
    logic           w_last_step;
    logic [W-1:0]   w_op_a;
    logic [W-1:0]   w_op_b;
    logic [W:0]     w_a_nxt;
    logic [W-1:0]   w_q_nxt;
    logic           w_qm1_nxt;

    // On a tie the requester that did not win last time is granted.
    assign w_g0 = req0_valid & (~req1_valid | r_last);
    assign w_g1 = req1_valid & (~req0_valid | ~r_last);

    assign req0_ready  = (r_state == IDLE) & w_g0 & ~rst;
    assign req1_ready  = (r_state == IDLE) & w_g1 & ~rst;
    assign w_accept    = (r_state == IDLE) & (w_g0 | w_g1);
    assign w_op_a      = w_g1 ? req1_a : req0_a;
    assign w_op_b      = w_g1 ? req1_b : req0_b;
    assign w_last_step = (r_cnt == CW'(W - 1));

    assign rsp_valid = (r_state == RESP);
    assign rsp_id    = r_id;
    assign rsp_ans   = {r_a[W-1:0], r_q};
    assign busy      = (r_state != IDLE);
    assign dbg_state = r_state;

    booth_step_dp #(.W(W)) u_step (
        .i_a   (r_a),
        .i_q   (r_q),
        .i_qm1 (r_qm1),
        .i_m   (r_m),
        .o_a   (w_a_nxt),
        .o_q   (w_q_nxt),
        .o_qm1 (w_qm1_nxt)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = CALC;
            CALC:    if (w_last_step) w_next = RESP;
            RESP:    if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_id    <= 1'b0;
            r_m     <= '0;
            r_a     <= '0;
            r_q     <= '0;
            r_qm1   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                // Sign-extending M by one bit keeps -2^(W-1) representable when negated.
                r_m    <= {w_op_a[W-1], w_op_a};
                r_a    <= '0;
                r_q    <= w_op_b;
                r_qm1  <= 1'b0;
                r_cnt  <= '0;
                r_id   <= w_g1;
                r_last <= w_g1;
            end else if (r_state == CALC) begin
                r_a   <= w_a_nxt;
                r_q   <= w_q_nxt;
                r_qm1 <= w_qm1_nxt;
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_booth_mul_sched.sv
// Self-checking bench for booth_mul_sched: vector table, scoreboard queue and
// directed sequences for backpressure, mid-operation reset and arbitration.
module tb_booth_mul_sched;
    import booth_pkg::*;

    localparam int W  = 5;
    localparam int PW = 2 * W;

    logic          clk;
    logic          rst;
    logic          req0_valid;
    logic [W-1:0]  req0_a;
    logic [W-1:0]  req0_b;
    logic          req0_ready;
    logic          req1_valid;
    logic [W-1:0]  req1_a;
    logic [W-1:0]  req1_b;
    logic          req1_ready;
    logic          rsp_valid;
    logic          rsp_id;
    logic [PW-1:0] rsp_ans;
    logic          rsp_ready;
    logic          busy;
    state_t        dbg_state;

    booth_mul_sched #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_ans    (rsp_ans),
        .rsp_ready  (rsp_ready),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [PW:0] exp_q[$];

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [PW-1:0] exp;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [PW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [PW-1:0] ea;
        logic [PW-1:0] eb;
        ea = {{W{a[W-1]}}, a};
        eb = {{W{b[W-1]}}, b};
        return ea * eb;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: expected event did not occur", name);
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (req0_ready && req1_ready)
                fail_now("both_ready");
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_rsp");
                end else begin
                    logic [PW:0] e;
                    e = exp_q.pop_front();
                    check("rsp_id", 32'(rsp_id), 32'(e[PW]));
                    check("rsp_ans", 32'(rsp_ans), 32'(e[PW-1:0]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit id, input logic [W-1:0] a, input logic [W-1:0] b);
        if (id == 1'b0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end
    endtask

    task automatic drop(input bit id);
        if (id == 1'b0) req0_valid = 1'b0;
        else            req1_valid = 1'b0;
    endtask

    // Call just after a rising edge; returns just after the accepting edge.
    task automatic do_req(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [PW-1:0] exp);
        bit got;
        got = 1'b0;
        drive(id, a, b);
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if ((id == 1'b0 && req0_ready) || (id == 1'b1 && req1_ready)) begin
                got = 1'b1;
                exp_q.push_back({id, exp});
            end
        end
        if (!got) fail_now("req_accept_timeout");
        @(posedge clk); #1;
        drop(id);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) done = 1'b1;
        end
        if (!done) fail_now("idle_timeout");
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int lat;
        bit seen;
        bit bad;
        int ng;
        bit grants[4];
        logic [PW-1:0] cap_ans;
        logic cap_id;

        rst = 1'b1;
        req0_valid = 1'b1; req0_a = 5'd7; req0_b = 5'd3;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b1;

        // Reset state, with a requester already valid.
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_req0_ready", 32'(req0_ready), 32'd0);
        check("rst_req1_ready", 32'(req1_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_ans", 32'(rsp_ans), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        @(posedge clk); #1;
        req0_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        // Single request: latency W+1 from the accept cycle.
        do_req(1'b0, 5'd7, 5'd3, 10'h015);
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (i == 0) check("busy_calc", 32'(busy), 32'd1);
            if (rsp_valid) seen = 1'b1;
        end
        check("latency", 32'(lat), 32'(W + 1));
        wait_idle();

        // Vector table: test-plan extremes plus random operands.
        tbl[0] = '{5'd7,  5'd3,  10'h015};
        tbl[1] = '{5'h10, 5'h10, 10'h100};
        tbl[2] = '{5'h10, 5'h0F, 10'h310};
        tbl[3] = '{5'd5,  5'h1D, 10'h3F1};
        tbl[4] = '{5'h1F, 5'h1F, 10'h001};
        tbl[5] = '{5'd0,  5'h10, 10'h000};
        for (int i = 6; i < 10; i++) begin
            tbl[i].a   = W'($urandom_range(0, 31));
            tbl[i].b   = W'($urandom_range(0, 31));
            tbl[i].exp = model(tbl[i].a, tbl[i].b);
        end
        for (int i = 0; i < 10; i++) begin
            do_req(i[0], tbl[i].a, tbl[i].b, tbl[i].exp);
            wait_idle();
        end

        // Backpressure: RESP held, outputs stable, no grants until release.
        rsp_ready = 1'b0;
        do_req(1'b0, 5'd5, 5'h1D, 10'h3F1);
        drive(1'b1, 5'd2, 5'd3);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        if (!seen) fail_now("bp_rsp_timeout");
        cap_ans = rsp_ans;
        cap_id  = rsp_id;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_ans", 32'(rsp_ans), 32'(cap_ans));
            check("bp_rsp_id", 32'(rsp_id), 32'(cap_id));
            check("bp_req0_ready", 32'(req0_ready), 32'd0);
            check("bp_req1_ready", 32'(req1_ready), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("no_accept_on_rsp", 32'(req1_ready), 32'd0);
        @(negedge clk);
        check("bp_idle_after", 32'(busy), 32'd0);
        check("bp_grant_after", 32'(req1_ready), 32'd1);
        if (req1_ready) exp_q.push_back({1'b1, 10'h006});
        @(posedge clk); #1;
        drop(1'b1);
        wait_idle();

        // Operands changed while busy must not affect the in-flight product.
        do_req(1'b1, 5'd6, 5'h19, 10'h3D6);
        req1_a = 5'h0F; req1_b = 5'h0F;
        @(posedge clk); #1;
        req1_a = 5'h11; req1_b = 5'h03;
        wait_idle();

        // Reset in the third CALC cycle discards the product.
        do_req(1'b0, 5'h09, 5'h0B, model(5'h09, 5'h0B));
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        bad = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (rsp_valid) bad = 1'b1;
        end
        check("midrst_no_rsp", 32'(bad), 32'd0);
        @(posedge clk); #1;
        drive(1'b0, 5'd2, 5'd3);
        drive(1'b1, 5'd4, 5'd5);
        @(negedge clk);
        check("tie_req0_ready", 32'(req0_ready), 32'd1);
        check("tie_req1_ready", 32'(req1_ready), 32'd0);
        if (req0_ready) exp_q.push_back({1'b0, 10'h006});
        @(posedge clk); #1;
        drop(1'b0);
        drop(1'b1);
        wait_idle();

        // Both requesters valid continuously: grants must alternate from 0.
        pulse_reset();
        drive(1'b0, 5'd3, 5'd4);
        drive(1'b1, 5'h1B, 5'd6);
        ng = 0;
        for (int c = 0; c < 200 && ng < 4; c++) begin
            @(negedge clk);
            if (req0_ready) begin
                exp_q.push_back({1'b0, 10'h00C});
                grants[ng] = 1'b0;
                ng++;
            end else if (req1_ready) begin
                exp_q.push_back({1'b1, 10'h3E2});
                grants[ng] = 1'b1;
                ng++;
            end
        end
        @(posedge clk); #1;
        drop(1'b0);
        drop(1'b1);
        check("rr_grant_count", 32'(ng), 32'd4);
        for (int k = 0; k < ng; k++)
            check("rr_grant_order", 32'(grants[k]), 32'(k % 2));
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
